// File: rtl/direction_pulser_if.sv
// direction_pulser_if: raw button levels into the pulser and the step pulses it produces.
// The master side drives the buttons and receives the pulses; the slave side is the pulser.
interface direction_pulser_if;
  logic i_btn_up;
  logic i_btn_down;
  logic i_btn_left;
  logic i_btn_right;
  logic o_up;
  logic o_down;
  logic o_left;
  logic o_right;

  modport master (
    output i_btn_up, i_btn_down, i_btn_left, i_btn_right,
    input  o_up, o_down, o_left, o_right
  );

  modport slave (
    input  i_btn_up, i_btn_down, i_btn_left, i_btn_right,
    output o_up, o_down, o_left, o_right
  );
endinterface

// File: rtl/direction_pulser.sv
// direction_pulser: turns four raw direction buttons into one-cycle step pulses.
// Each button is synchronized, debounced and fed to a small press FSM; opposing
// directions that fire in the same cycle cancel each other.
// Optional auto-repeat while held: define DIRECTION_PULSER_AUTO_REPEAT_EN.
// Channel order in all 4-bit vectors: [0]=up [1]=down [2]=left [3]=right.
module direction_pulser #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  direction_pulser_if.slave io_pad
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  // Reject configurations that make a timer compare against a negative count.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("direction_pulser: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

`ifdef DIRECTION_PULSER_AUTO_REPEAT_EN
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } t_state;

  logic [TMR_W-1:0] r_tmr     [4];
  logic [TMR_W-1:0] w_tmr_nxt [4];
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } t_state;
`endif

  logic [3:0]       w_raw;
  logic [3:0]       r_sync1;
  logic [3:0]       r_sync2;
  logic [3:0]       r_db;
  logic [CNT_W-1:0] r_cnt [4];
  t_state           r_state     [4];
  t_state           w_state_nxt [4];
  logic [3:0]       w_req;
  logic [3:0]       w_pulse;
  logic [3:0]       r_pulse;
  logic [3:0]       r_out;

  assign w_raw = {io_pad.i_btn_right, io_pad.i_btn_left, io_pad.i_btn_down, io_pad.i_btn_up};

  // Two-flop synchronizer for the asynchronous button levels.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      // NOTE: non-blocking assignments so r_sync2 takes the old r_sync1, giving two real flops.
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: flip the accepted level after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_db <= '0;
      // NOTE: the counter array is only four small registers, so it is reset like any flop.
      for (int b = 0; b < 4; b++) r_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (r_sync2[b] == r_db[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          // This is the DEBOUNCE_CYCLES-th differing sample; the count never passes it.
          r_db[b]  <= ~r_db[b];
          r_cnt[b] <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  // Press FSM state (and repeat timer) registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int b = 0; b < 4; b++) begin
        r_state[b] <= ST_IDLE;
`ifdef DIRECTION_PULSER_AUTO_REPEAT_EN
        r_tmr[b]   <= '0;
`endif
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        r_state[b] <= w_state_nxt[b];
`ifdef DIRECTION_PULSER_AUTO_REPEAT_EN
        r_tmr[b]   <= w_tmr_nxt[b];
`endif
      end
    end
  end

  // Press FSM next state: request a pulse on press and, if enabled, on each repeat tick.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      w_state_nxt[b] = r_state[b];
      w_req[b]       = 1'b0;
`ifdef DIRECTION_PULSER_AUTO_REPEAT_EN
      w_tmr_nxt[b]   = r_tmr[b];
      case (r_state[b])
        ST_IDLE: begin
          if (r_db[b]) begin
            w_req[b]       = 1'b1;
            w_state_nxt[b] = ST_DELAY;
            w_tmr_nxt[b]   = '0;
          end
        end
        ST_DELAY: begin
          if (!r_db[b]) begin
            w_state_nxt[b] = ST_IDLE;
            w_tmr_nxt[b]   = '0;
          end else if (r_tmr[b] == TMR_W'(REPEAT_DELAY - 1)) begin
            w_req[b]       = 1'b1;
            w_state_nxt[b] = ST_REPEAT;
            w_tmr_nxt[b]   = '0;
          end else begin
            w_tmr_nxt[b]   = r_tmr[b] + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!r_db[b]) begin
            w_state_nxt[b] = ST_IDLE;
            w_tmr_nxt[b]   = '0;
          end else if (r_tmr[b] == TMR_W'(REPEAT_PERIOD - 1)) begin
            w_req[b]       = 1'b1;
            w_tmr_nxt[b]   = '0;
          end else begin
            w_tmr_nxt[b]   = r_tmr[b] + 1'b1;
          end
        end
        default: begin
          w_state_nxt[b] = ST_IDLE;
          w_tmr_nxt[b]   = '0;
        end
      endcase
`else
      case (r_state[b])
        ST_IDLE: begin
          if (r_db[b]) begin
            w_req[b]       = 1'b1;
            w_state_nxt[b] = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!r_db[b]) w_state_nxt[b] = ST_IDLE;
        end
        default: w_state_nxt[b] = ST_IDLE;
      endcase
`endif
    end
  end

  // Opposing directions requested together cancel; the FSMs advance regardless.
  assign w_pulse = w_req & ~{w_req[2], w_req[3], w_req[0], w_req[1]};

  // Output stage: registered pulses, never high two cycles running.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_pulse <= '0;
      r_out   <= '0;
    end else begin
      r_pulse <= w_pulse;
      r_out   <= r_pulse & ~r_out;
    end
  end

  assign io_pad.o_up    = r_out[0];
  assign io_pad.o_down  = r_out[1];
  assign io_pad.o_left  = r_out[2];
  assign io_pad.o_right = r_out[3];

endmodule

// File: tb/tb_direction_pulser.sv
// tb_direction_pulser: directed vector tables for the press/bounce/repeat/opposing/reset
// cases, then randomized bouncy stimulus against a timeline-based reference model.
// Expected repeat behaviour follows DIRECTION_PULSER_AUTO_REPEAT_EN as compiled.
module tb_direction_pulser;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;
  localparam int MAXN = 4096;
`ifdef DIRECTION_PULSER_AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] outs;

  direction_pulser_if pad ();

  direction_pulser #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .i_Clk  (clk),
    .i_Rst  (rst),
    .io_pad (pad)
  );

  always #5 clk = ~clk;

  assign outs = {pad.o_right, pad.o_left, pad.o_down, pad.o_up};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Works on a timeline of clock edges since the last reset: the synchronized sample at
  // edge n is the raw level from edge n-2; the level is accepted once the last DEB samples
  // (all taken after the previous acceptance) disagree with it; the press FSM sees the
  // accepted level one edge later; output rises one edge after the request.
  bit m_raw [4][MAXN];
  bit m_s   [4][MAXN];
  bit m_req [4][MAXN];
  int n;
  int last_tog [4];
  bit db       [4];
  bit inhold   [4];
  int start    [4];

  task automatic model_reset();
    n = 0;
    for (int b = 0; b < 4; b++) begin
      last_tog[b] = -1;
      db[b]       = 1'b0;
      inhold[b]   = 1'b0;
      start[b]    = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] btn, output logic [3:0] exp_o);
    bit ok;
    bit seen;
    if (n >= MAXN) begin
      $display("FAIL model_depth: got %0d edges need < %0d", n, MAXN);
      $fatal(1, "reference model timeline overflow");
    end
    for (int b = 0; b < 4; b++) begin
      m_raw[b][n] = btn[b];
      m_s[b][n]   = (n >= 2) ? m_raw[b][n-2] : 1'b0;
      ok = (n - DEB + 1) > last_tog[b];
      if (ok) begin
        for (int k = n - DEB + 1; k <= n; k++) if (m_s[b][k] == db[b]) ok = 1'b0;
      end
      seen = db[b];  // level accepted as of the previous edge
      if (ok) begin
        db[b]       = ~db[b];
        last_tog[b] = n;
      end
      if (n == 0) seen = 1'b0;
      if (seen) begin
        if (!inhold[b]) begin
          inhold[b]   = 1'b1;
          start[b]    = n;
          m_req[b][n] = 1'b1;
        end else begin
          m_req[b][n] = AR && ((n - start[b]) >= RD) && (((n - start[b] - RD) % RP) == 0);
        end
      end else begin
        inhold[b]   = 1'b0;
        m_req[b][n] = 1'b0;
      end
    end
    for (int b = 0; b < 4; b++)
      exp_o[b] = (n >= 1) ? (m_req[b][n-1] & ~m_req[b ^ 1][n-1]) : 1'b0;
    n++;
  endtask

  // One clock: drive inputs at the falling edge, let the rising edge happen, sample at
  // the next falling edge, and advance the model by that rising edge.
  task automatic step(input bit r, input logic [3:0] btn,
                      output logic [3:0] exp_m, output logic [3:0] act);
    rst = r;
    pad.i_btn_up    = btn[0];
    pad.i_btn_down  = btn[1];
    pad.i_btn_left  = btn[2];
    pad.i_btn_right = btn[3];
    @(negedge clk);
    act = outs;
    if (r) begin
      model_reset();
      exp_m = 4'b0000;
    end else begin
      model_edge(btn, exp_m);
    end
  endtask

  // ---------------- vector tables ----------------
  typedef struct packed {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl [$];

  function automatic void add(input logic r, input logic [3:0] btn, input logic [3:0] exp);
    vec_t v;
    v.rst = r;
    v.btn = btn;
    v.exp = exp;
    tbl.push_back(v);
  endfunction

  function automatic void add_reset();
    add(1'b1, 4'b0000, 4'b0000);
    add(1'b1, 4'b0000, 4'b0000);
  endfunction

  task automatic run_table(input string name);
    logic [3:0] em;
    logic [3:0] act;
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].btn, em, act);
      check($sformatf("%s_vec[%0d]", name, i), act, tbl[i].exp);
      check($sformatf("%s_model[%0d]", name, i), act, em);
    end
    tbl.delete();
  endtask

  function automatic bit repeat_hit(input int c);
    return (c == 7) || (AR && (c == 17 || c == 22 || c == 27));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] em;
    logic [3:0] act;
    logic [3:0] lvl;
    logic [3:0] btn;
    int         since_rst;

    pad.i_btn_up    = 1'b0;
    pad.i_btn_down  = 1'b0;
    pad.i_btn_left  = 1'b0;
    pad.i_btn_right = 1'b0;
    model_reset();
    @(negedge clk);

    // Short press: up for 6 cycles -> one pulse in cycle 7, no repeat after release.
    add_reset();
    for (int c = 0; c < 20; c++) add(1'b0, (c < 6) ? 4'b0001 : 4'b0000, (c == 7) ? 4'b0001 : 4'b0000);
    run_table("press_release");

    // Bouncy left: 3 high, 2 low, 3 high -> never accepted.
    add_reset();
    for (int c = 0; c < 16; c++)
      add(1'b0, ((c < 3) || (c >= 5 && c < 8)) ? 4'b0100 : 4'b0000, 4'b0000);
    run_table("bounce");

    // Right held cycles 0..30: press pulse plus repeats (when enabled), window 0..31.
    add_reset();
    for (int c = 0; c < 32; c++)
      add(1'b0, (c <= 30) ? 4'b1000 : 4'b0000, repeat_hit(c) ? 4'b1000 : 4'b0000);
    run_table("hold_right");

    // Up and down together: every pulse cancelled.
    add_reset();
    for (int c = 0; c < 30; c++) add(1'b0, 4'b0011, 4'b0000);
    run_table("opposing");

    // Up and right together: independent, both pulse in cycle 7.
    add_reset();
    for (int c = 0; c < 13; c++) add(1'b0, 4'b1001, (c == 7) ? 4'b1001 : 4'b0000);
    run_table("non_opposing");

    // Down held with reset pulsed in cycles 12..13: new press 7 cycles after release.
    add_reset();
    for (int c = 0; c < 29; c++)
      add((c == 12 || c == 13), 4'b0010, (c == 7 || c == 21) ? 4'b0010 : 4'b0000);
    run_table("reset_mid_hold");

    // Up held cycles 0..30: one pulse without repeat, pulse train with it.
    add_reset();
    for (int c = 0; c < 31; c++) add(1'b0, 4'b0001, repeat_hit(c) ? 4'b0001 : 4'b0000);
    run_table("hold_up");

    // Reset clears a live output pulse without waiting for a clock edge.
    add_reset();
    for (int c = 0; c < 8; c++) add(1'b0, 4'b0100, (c == 7) ? 4'b0100 : 4'b0000);
    run_table("async_pre");
    rst = 1'b1;
    #1;
    check("async_rst", outs, 4'b0000);
    model_reset();
    add_reset();
    for (int c = 0; c < 10; c++) add(1'b0, 4'b0000, 4'b0000);
    run_table("async_post");

    // Randomized bouncy buttons with occasional resets, checked against the model.
    lvl = 4'b0000;
    since_rst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit r;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 39) == 0) lvl[b] = ~lvl[b];
      if ($urandom_range(0, 59) == 0) begin
        lvl[0] = $urandom_range(0, 1);
        lvl[1] = lvl[0];
      end
      if ($urandom_range(0, 59) == 0) begin
        lvl[2] = $urandom_range(0, 1);
        lvl[3] = lvl[2];
      end
      for (int b = 0; b < 4; b++) btn[b] = lvl[b] ^ ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 499) == 0) || (since_rst > 1500);
      since_rst = r ? 0 : since_rst + 1;
      step(r, btn, em, act);
      check($sformatf("random[%0d]", cyc), act, em);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule

// File: doc/direction_pulser.md
DIRECTION_PULSER -- requirements
Module: direction_pulser

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 250000, which is the number of consecutive stable synchronized samples needed to accept a level change (10 ms at 25 MHz).
REQ-002 The block SHALL have parameter REPEAT_DELAY, default 12500000, which is the number of cycles from the press pulse to the first auto-repeat pulse.
REQ-003 The block SHALL have parameter REPEAT_PERIOD, default 2500000, which is the number of cycles between subsequent auto-repeat pulses.
REQ-004 The block SHALL have port i_Clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port i_Rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have ports i_btn_up, i_btn_down, i_btn_left, i_btn_right, input, 1 bit each: raw, asynchronous button levels, where 1 means pressed.
REQ-007 The block SHALL have ports o_up, o_down, o_left, o_right, output, 1 bit each: registered one-cycle step pulses that drive the movement block's i_up, i_down, i_left and i_right inputs.

Function
REQ-008 Each button SHALL pass through a two-flop synchronizer before any other logic uses it.
REQ-009 Per button: the debounced state SHALL toggle only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it.
REQ-010 The debounce counter SHALL clear on any sample that equals the debounced state.
REQ-011 The debounce counter width SHALL be clog2(DEBOUNCE_CYCLES+1), and the counter SHALL saturate and never wrap.
REQ-012 A debounced 0->1 transition SHALL produce exactly one output pulse.
REQ-013 Press latency SHALL be DEBOUNCE_CYCLES+3 cycles from the first i_Clk edge that samples the new raw level to the cycle in which the output is high.
REQ-014 A bounce shorter than DEBOUNCE_CYCLES samples SHALL produce no pulse and no state change.
REQ-015 A debounced 1->0 transition (release) SHALL produce no pulse.
REQ-016 Each output SHALL be high for exactly one cycle per pulse and SHALL never be high on two consecutive cycles.
REQ-017 Per-button FSM: IDLE -> (debounced press, emit pulse) -> DELAY.
REQ-018 FSM transition: DELAY -> (REPEAT_DELAY cycles elapsed since press pulse, emit pulse) -> REPEAT.
REQ-019 FSM transition: REPEAT -> (REPEAT_PERIOD cycles elapsed since last pulse, emit pulse) -> REPEAT.
REQ-020 A debounced release in DELAY or REPEAT SHALL return the FSM to IDLE in the same cycle and clear its timer, with no pulse emitted.
REQ-021 Opposing pairs (up/down, left/right): if both members would pulse in the same cycle, both pulses SHALL be suppressed, and both FSMs and timers SHALL advance as if the pulses had been emitted.
REQ-022 Non-opposing directions (e.g. up and right) SHALL pulse independently, including in the same cycle.
REQ-023 The four button channels SHALL be fully independent except for the rule in REQ-021.

Reset
REQ-024 Asserting i_Rst SHALL immediately force all outputs to 0, synchronizers to 0, debounced states to 0, all counters and timers to 0, and all FSMs to IDLE, without waiting for a clock edge.
REQ-025 Reset asserted mid-debounce or mid-repeat SHALL discard all progress, so no pulse is produced by pre-reset history.
REQ-026 A button held through reset deassertion SHALL be treated as a new press and SHALL pulse DEBOUNCE_CYCLES+3 cycles after the first post-reset edge.

Configuration
REQ-027 Macro DIRECTION_PULSER_AUTO_REPEAT_EN defined: DELAY and REPEAT states and the repeat timers SHALL be compiled in, and behaviour SHALL follow REQ-017 to REQ-020.
REQ-028 Macro DIRECTION_PULSER_AUTO_REPEAT_EN undefined: no repeat logic SHALL be synthesized, exactly one pulse SHALL be emitted per debounced press, and the REPEAT_DELAY and REPEAT_PERIOD parameters SHALL be ignored.

Verification (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, auto-repeat enabled unless stated)
REQ-029 The bench SHALL cover: i_btn_up rises at cycle 0 and is held for 6 cycles, then released -> o_up high only in cycle 7, with no repeat pulses.
REQ-030 The bench SHALL cover: i_btn_left high for 3 cycles, low for 2, high for 3, then low -> o_left never asserts.
REQ-031 The bench SHALL cover: i_btn_right held from cycle 0 to cycle 30 -> o_right pulses in cycles 7, 17, 22 and 27 only.
REQ-032 The bench SHALL cover: i_btn_up and i_btn_down rise together at cycle 0 and are held -> o_up and o_down stay 0 throughout; repeat with i_btn_up and i_btn_right -> both pulse in cycle 7.
REQ-033 The bench SHALL cover: i_btn_down held, with i_Rst pulsed high at cycle 12 and released at cycle 14 -> outputs are 0 from cycle 12, and the next o_down pulse occurs 7 cycles after the first post-reset edge.
REQ-034 The bench SHALL cover: i_btn_up held from cycle 0 to cycle 30 with the macro undefined -> the only o_up pulse is in cycle 7.
